// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder/subtractor: one decimal digit per clock, LSD first,
// with decimal correction, carry/borrow and an invalid-BCD check at acceptance.
module bcd_serial_adder #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                Sub,
  input  logic [4*DIGITS-1:0] A,
  input  logic [4*DIGITS-1:0] B,
  input  logic                Cin,
  output logic [4*DIGITS-1:0] Sum,
  output logic                Cout,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             sub_q, sub_d, carry_q, carry_d;
  logic             cout_q, cout_d, err_q, err_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [3:0] digit_a, digit_b, digit_bx, digit_s;
  logic [4:0] digit_t;
  logic       carry_next;

  function automatic logic has_invalid(input logic [W-1:0] v);
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Subtraction adds the nine's complement of B with an initial carry of 1.
  always_comb begin
    digit_a    = a_q[{idx_q, 2'b00} +: 4];
    digit_b    = b_q[{idx_q, 2'b00} +: 4];
    digit_bx   = sub_q ? (4'd9 - digit_b) : digit_b;
    digit_t    = {1'b0, digit_a} + {1'b0, digit_bx} + {4'b0000, carry_q};
    digit_s    = digit_t[3:0];
    carry_next = 1'b0;
    if (digit_t > 5'd9) begin
      digit_s    = 4'(digit_t - 5'd10);
      carry_next = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    err_d   = err_q;

    case (state_q)
      RUN: begin
        sum_d[{idx_q, 2'b00} +: 4] = digit_s;
        carry_d = carry_next;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(DIGITS - 1)) begin
          cout_d  = carry_next;
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        if (start) begin
          a_d     = A;
          b_d     = B;
          sub_d   = Sub;
          carry_d = Sub ? 1'b1 : Cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          err_d   = 1'b0;
          state_d = RUN;
          // Malformed operands skip straight to DONE with a zero result.
          if (has_invalid(A) || has_invalid(B)) begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Sum  = sum_q;
  assign Cout = cout_q;
  assign err  = err_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: doc/bcd_serial_adder.md
# bcd_serial_adder

Parametrised, digit-serial packed-BCD adder/subtractor for the BCD adder family. It accepts two DIGITS-wide BCD operands on a start strobe and processes one decimal digit per clock, least-significant first, with decimal correction and carry/borrow. It flags invalid BCD input and is intended for multi-digit decimal datapaths where area matters more than latency.

## Interface
- DIGITS, default 4: number of BCD digits per operand; legal range 1..16.
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  operation request; accepted only when busy=0.
- Sub  input  1  mode: 0 = A+B+Cin, 1 = A−B (ten's complement).
- A  input  4*DIGITS  packed BCD operand; digit i occupies A[4i+3:4i].
- B  input  4*DIGITS  packed BCD operand, same packing as A.
- Cin  input  1  decimal carry-in for digit 0; ignored when Sub=1.
- Sum  output  4*DIGITS  packed BCD result.
- Cout  output  1  decimal carry-out. In Sub mode, 1 means no borrow (A≥B).
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse when the result is valid.
- err  output  1  invalid-BCD flag; valid with done.

## Operation
- FSM states: IDLE, RUN, DONE.
  - Reset → IDLE.
- Acceptance: start=1 sampled at an edge while in IDLE or DONE is accepted. On acceptance the block:
  - latches A, B, Sub and Cin;
  - clears Sum, Cout and err;
  - sets digit index to 0.
- Input check at acceptance: if any digit of A or B is greater than 9:
  - err=1, Sum=0, Cout=0;
  - next state is DONE, with no RUN cycles.
- Otherwise the next state is RUN. The internal carry c is initialised to Cin when Sub=0, and to 1 when Sub=1.
- Each RUN cycle processes digit i:
  - b = Sub ? 9−B_i : B_i;
  - t = A_i + b + c, a 5-bit value with range 0..19;
  - if t>9: Sum_i = t−10 and c=1; otherwise Sum_i = t and c=0;
  - i increments by 1.
- When i=DIGITS−1 has been processed: Cout = final c, and the next state is DONE.
- DONE lasts one cycle with done=1.
  - Next state is RUN or DONE if start is accepted in that cycle; otherwise IDLE.
- Sub result is the ten's complement. A<B gives 10^DIGITS − (B−A) with Cout=0.
- start while busy=1 is ignored. It is not queued, and the latched operands are unaffected.

## Timing
- Reset values:
  - Sum=0, Cout=0, busy=0, done=0, err=0;
  - state IDLE.
  - Reset mid-operation aborts immediately; no done is issued.
- busy=1 in the RUN state only. busy=0 in IDLE and DONE, which allows back-to-back operations.
- Valid operation accepted at edge E0: digits are processed at edges E1..E_DIGITS, and done=1 in the cycle following edge E_DIGITS. Latency from the start edge to done is DIGITS+1 cycles.
- Error case: done=1 in the cycle immediately after E0, so latency is 1 cycle.
- Sum, Cout and err:
  - hold their values after done until the next accepted start;
  - Sum is undefined mid-operation, since it is partially filled.
- Back-to-back: start=1 during the done cycle is accepted at that edge. The next done follows after DIGITS+1 cycles, with no idle cycle in between.
- DIGITS=1: a single RUN cycle.

## Test plan
- Addition:
  - Stimulus: DIGITS=4, Sub=0, Cin=0, A=0x1234, B=0x5678, start for 1 cycle.
  - Required response: busy for 4 cycles, then done with Sum=0x6912, Cout=0, err=0.
- Full carry ripple:
  - Stimulus: A=0x9999, B=0x0000, Cin=1.
  - Required response: Sum=0x0000, Cout=1.
- Subtraction, both signs:
  - Stimulus 1: Sub=1, A=0x5000, B=0x1234. Required response: Sum=0x3766, Cout=1.
  - Stimulus 2: A=0x1234, B=0x5000. Required response: Sum=0x6234, Cout=0.
  - Both cases: Cin toggled has no effect.
- Invalid BCD:
  - Stimulus: A=0x12A4, B=0x0001.
  - Required response: done one cycle after start, err=1, Sum=0, Cout=0, busy never 1.
- Back-to-back and ignore:
  - Stimulus: start held high continuously, with operands changed mid-RUN.
  - Required response: mid-RUN changes do not affect the result; a new operation is accepted exactly at each done cycle.
- Async reset:
  - Stimulus: assert rst at cycle 2 of RUN, between clock edges.
  - Required response: all outputs are 0 at once; no done pulse follows; a subsequent start completes normally.
